// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, byte width and defaults for the
// UART Tx sharing logic.
package uart_pkg;

    localparam int BYTE_W          = 8;
    localparam int DEF_MAX_BURST   = 16;
    localparam int DEF_TIMEOUT_CYC = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin selector; searches from ptr+1
// upward (mod N) and returns the first set request.
module uart_rr_pick #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!any && req[(int'(ptr) + k) % N]) begin
                any                           = 1'b1;
                onehot[(int'(ptr) + k) % N]   = 1'b1;
                idx                           = IW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin sharing of one UART Tx among NUM_REQ byte streams.
// Optional idle-grant watchdog is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MAX_BURST   = DEF_MAX_BURST,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      tx_start,
    output logic [BYTE_W-1:0]         tx_data,
    input  logic                      tx_done,
    output logic                      timeout_err
);

    localparam int IW = $clog2(NUM_REQ);

    arb_state_t          state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       gidx_q, gidx_d;
    logic [NUM_REQ-1:0]  grant_d;
    logic [7:0]          burst_q, burst_d;
    logic                last_q, last_d;
    logic                tx_start_d;
    logic [BYTE_W-1:0]   tx_data_d;
    logic [NUM_REQ-1:0]  pick_oh;
    logic [IW-1:0]       pick_idx;
    logic                pick_any;
    logic                hs;
    logic                burst_end;
    logic                release_to;

    uart_rr_pick #(
        .N      (NUM_REQ)
    ) u_pick (
        .req    (req_valid),
        .ptr    (ptr_q),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign hs        = (state_q == ST_LOAD) && req_valid[gidx_q];
    assign req_ready = hs ? grant : '0;
    assign burst_end = last_q || (burst_q == 8'(MAX_BURST));

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] to_cnt_q;
    logic          to_err_q;

    // Counter sits at zero outside LOAD, so LOAD entry always starts clean.
    assign release_to = (state_q == ST_LOAD) && !req_valid[gidx_q] &&
                        (to_cnt_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else begin
            to_err_q <= release_to;
            if (state_q != ST_LOAD || hs)
                to_cnt_q <= '0;
            else if (!release_to)
                to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    assign timeout_err = to_err_q;
`else
    assign release_to  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gidx_d     = gidx_q;
        grant_d    = grant;
        burst_d    = burst_q;
        last_d     = last_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_oh;
                    gidx_d  = pick_idx;
                    burst_d = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (hs) begin
                    tx_data_d  = req_data[gidx_q*BYTE_W +: BYTE_W];
                    tx_start_d = 1'b1;
                    last_d     = req_last[gidx_q];
                    if (burst_q != 8'hFF)
                        burst_d = burst_q + 8'd1;
                    state_d    = ST_WAIT;
                end else if (release_to) begin
                    ptr_d   = gidx_q;
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // A done coinciding with our own start cannot be ours.
                if (tx_done && !tx_start) begin
                    if (burst_end) begin
                        ptr_d   = gidx_q;
                        grant_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= IW'(NUM_REQ - 1);
            gidx_q   <= '0;
            grant    <= '0;
            burst_q  <= '0;
            last_q   <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            grant    <= grant_d;
            burst_q  <= burst_d;
            last_q   <= last_d;
            tx_start <= tx_start_d;
            tx_data  <= tx_data_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: transaction-level scoreboard bench for uart_tx_arb,
// plus a second instance with MAX_BURST=2 for forced-release ordering.
module tb_uart_tx_arb;

    localparam int N      = 4;
    localparam int MB     = 16;
    localparam int TO     = 8;
    localparam int TX_LAT = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_last, req_ready, grant;
    logic [8*N-1:0] req_data;
    logic           tx_start, tx_done, timeout_err;
    logic [7:0]     tx_data;

    logic [N-1:0]   b_valid, b_last, b_ready, b_grant;
    logic [8*N-1:0] b_data;
    logic           b_start, b_done, b_to;
    logic [7:0]     b_txd;

    always #5 clk = ~clk;

    uart_tx_arb #(.NUM_REQ(N), .MAX_BURST(MB), .TIMEOUT_CYC(TO)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .grant(grant),
        .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
        .timeout_err(timeout_err)
    );

    uart_tx_arb #(.NUM_REQ(N), .MAX_BURST(2), .TIMEOUT_CYC(TO)) u_b2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_valid), .req_data(b_data), .req_last(b_last),
        .req_ready(b_ready), .grant(b_grant),
        .tx_start(b_start), .tx_data(b_txd), .tx_done(b_done),
        .timeout_err(b_to)
    );

    int n_chk = 0;
    int n_err = 0;
    logic [8:0] drv_q [N][$];
    logic [8:0] exp_q [N][$];
    int owner = -1, mptr = N - 1, burst = 0, starts = 0, tcnt = 0, cyc = 0;
    int load_at = 0, to_gap = -1, to_pulses = 0;
    bit last_flag = 0, in_wait = 0, start_last = 0, echo_done = 0, spur = 0;
    logic [7:0] wdata = '0;
    logic [N-1:0] hs = '0;
    int own_log[$];
    logic [7:0] dat_log[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: got event, required none/limit (cycle %0d)", name, cyc);
    endtask

    function automatic int rr(input logic [N-1:0] v, input int p);
        for (int k = 1; k <= N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < N; i++)
            if (drv_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push(input int i, input logic [7:0] d, input logic l);
        drv_q[i].push_back({l, d});
        exp_q[i].push_back({l, d});
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            drv_q[i].delete();
            exp_q[i].delete();
        end
        owner = -1; mptr = N - 1; burst = 0; starts = 0; tcnt = 0;
        in_wait = 0; start_last = 0; last_flag = 0; hs = '0;
    endtask

    // Scoreboard: outputs seen after each rising edge vs. the arbitration rules.
    task automatic monitor();
        logic [N-1:0] vin;
        logic [8:0]   e;
        int           pk;
        bit           rel;
        vin = req_valid;
        rel = 1'b0;
        if (!rst_n) begin
            chk("rst_grant", 32'(grant), 32'd0);
            chk("rst_tx_start", 32'(tx_start), 32'd0);
            chk("rst_tx_data", 32'(tx_data), 32'd0);
            chk("rst_timeout", 32'(timeout_err), 32'd0);
            model_reset();
            return;
        end
`ifndef UART_ARB_TIMEOUT_EN
        chk("timeout_off", 32'(timeout_err), 32'd0);
`endif
        if (tx_done && in_wait && !start_last) begin
            in_wait = 1'b0;
            starts  = 0;
            if (last_flag || burst == MB) rel = 1'b1;
            else load_at = cyc;
        end
        if (owner < 0) begin
            pk = rr(vin, mptr);
            chk("grant_pick", 32'(grant), (pk < 0) ? 32'd0 : (32'd1 << pk));
            if (pk >= 0) begin
                owner = pk; burst = 0; load_at = cyc;
            end
        end else if (rel || timeout_err) begin
            chk("grant_release", 32'(grant), 32'd0);
            if (timeout_err) begin
                to_gap = cyc - load_at;
                to_pulses++;
            end
            mptr  = owner;
            owner = -1;
        end else begin
            chk("grant_hold", 32'(grant), 32'd1 << owner);
        end
        chk("tx_start", 32'(tx_start), 32'(hs != '0));
        if (tx_start) begin
            if (owner < 0 || exp_q[owner].size() == 0) begin
                fail_now("tx_unexpected");
            end else begin
                e = exp_q[owner].pop_front();
                chk("tx_data", 32'(tx_data), 32'(e[7:0]));
                chk("one_start_per_done", 32'(starts), 32'd0);
                last_flag = e[8];
                burst++;
                starts++;
                in_wait = 1'b1;
                wdata   = tx_data;
                own_log.push_back(owner);
                dat_log.push_back(tx_data);
            end
            start_last = 1'b1;
        end else begin
            start_last = 1'b0;
            if (in_wait) chk("tx_data_hold", 32'(tx_data), 32'(wdata));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        monitor();
        for (int i = 0; i < N; i++)
            if (hs[i] && drv_q[i].size() > 0) drv_q[i].delete(0);
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = drv_q[i].size() > 0;
            req_data[8*i +: 8] = (drv_q[i].size() > 0) ? drv_q[i][0][7:0] : 8'h00;
            req_last[i]        = (drv_q[i].size() > 0) ? drv_q[i][0][8] : 1'b0;
        end
        tx_done = 1'b0;
        if (tcnt > 0) begin
            tcnt--;
            if (tcnt == 0) tx_done = 1'b1;
        end
        if (tx_start && owner >= 0) begin
            tcnt = TX_LAT;
            if (echo_done) tx_done = 1'b1;
        end
        if (spur) begin
            tx_done = 1'b1;
            spur    = 1'b0;
        end
        #2;
        hs = req_ready & req_valid;
        chk("ready_in_grant", 32'(req_ready & ~grant), 32'd0);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (!(owner < 0 && !in_wait && tcnt == 0 && all_empty()) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) fail_now(name);
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic run_b2();
        int n3 = 0, n0 = 0, bt = 0;
        logic [N-1:0] bhs = '0;
        logic [N-1:0] bo[$];
        logic [7:0]   bd[$];
        logic [N-1:0] eo[7] = '{4'b1000, 4'b1000, 4'b0001, 4'b1000, 4'b1000, 4'b0001, 4'b1000};
        logic [7:0]   ed[7] = '{8'h01, 8'h02, 8'hE0, 8'h03, 8'h04, 8'hE1, 8'h05};
        for (int k = 0; k < 400 && bo.size() < 7; k++) begin
            @(negedge clk);
            b_done = 1'b0;
            if (b_start) begin
                bo.push_back(b_grant);
                bd.push_back(b_txd);
                bt = TX_LAT;
            end else if (bt > 0) begin
                bt--;
                if (bt == 0) b_done = 1'b1;
            end
            if (bhs[3]) n3++;
            if (bhs[0]) n0++;
            b_valid           = {n3 < 5, 2'b00, k >= 1};
            b_data[31:24]     = 8'(n3 + 1);
            b_last[3]         = (n3 == 4);
            b_data[7:0]       = 8'hE0 + 8'(n0);
            b_last[0]         = 1'b1;
            #2;
            bhs = b_ready & b_valid;
        end
        b_valid = '0;
        if (bo.size() < 7) fail_now("b2_timeout");
        for (int k = 0; k < bo.size(); k++) begin
            chk("b2_grant", 32'(bo[k]), 32'(eo[k]));
            chk("b2_data", 32'(bd[k]), 32'(ed[k]));
        end
    endtask

    initial begin
        int ex_o[5] = '{0, 1, 2, 3, 0};
        int s0;
        rst_n = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0; tx_done = 1'b0;
        b_valid = '0; b_data = '0; b_last = '0; b_done = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        // single requester, cycle-exact latency
        push(1, 8'hA5, 1'b1);
        tick();
        tick();
        chk("single_grant_c1", 32'(grant), 32'h2);
        chk("single_ready_c1", 32'(req_ready), 32'h2);
        tick();
        chk("single_start_c2", 32'(tx_start), 32'd1);
        chk("single_data_c2", 32'(tx_data), 32'hA5);
        wait_idle("single_idle_timeout", 100);
        chk("single_grant_off", 32'(grant), 32'd0);
        push(0, 8'hC0, 1'b1);
        push(1, 8'hC1, 1'b1);
        push(2, 8'hC2, 1'b1);
        tick();
        tick();
        chk("ptr_after_single", 32'(grant), 32'h4);
        wait_idle("ptr_idle_timeout", 200);

        // round robin from reset
        do_reset();
        own_log.delete();
        dat_log.delete();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push(i, 8'(i), 1'b1);
        wait_idle("rr_timeout", 400);
        chk("rr_count", 32'(own_log.size()), 32'd8);
        for (int k = 0; k < 5 && k < own_log.size(); k++) begin
            chk("rr_order", 32'(own_log[k]), 32'(ex_o[k]));
            chk("rr_data", 32'(dat_log[k]), 32'(ex_o[k]));
        end

        // packet lock, with a done echoed in each start cycle
        own_log.delete();
        dat_log.delete();
        echo_done = 1'b1;
        push(0, 8'h11, 1'b0);
        push(0, 8'h22, 1'b0);
        push(0, 8'h33, 1'b1);
        push(2, 8'h44, 1'b1);
        wait_idle("lock_timeout", 300);
        echo_done = 1'b0;
        chk("lock_count", 32'(dat_log.size()), 32'd4);
        if (dat_log.size() == 4) begin
            chk("lock_b0", 32'(dat_log[0]), 32'h11);
            chk("lock_b1", 32'(dat_log[1]), 32'h22);
            chk("lock_b2", 32'(dat_log[2]), 32'h33);
            chk("lock_b3", 32'(dat_log[3]), 32'h44);
            chk("lock_own3", 32'(own_log[3]), 32'd2);
        end

        run_b2();

        // reset during WAIT, then a stray done while idle
        push(1, 8'h5A, 1'b0);
        push(1, 8'h5B, 1'b1);
        s0 = 0;
        while (!tx_start && s0 < 50) begin
            tick();
            s0++;
        end
        if (s0 >= 50) fail_now("rst_wait_start");
        rst_n = 1'b0;
        tick();
        chk("rst_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        s0 = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (tx_start) s0++;
        end
        chk("rst_no_start", 32'(s0), 32'd0);
        spur = 1'b1;
        tick();
        tick();
        tick();
        chk("spur_grant", 32'(grant), 32'd0);
        chk("spur_start", 32'(tx_start), 32'd0);
        push(2, 8'h66, 1'b1);
        wait_idle("post_rst_timeout", 100);
        chk("post_rst_data", 32'(dat_log[dat_log.size()-1]), 32'h66);

`ifdef UART_ARB_TIMEOUT_EN
        do_reset();
        own_log.delete();
        dat_log.delete();
        push(1, 8'h77, 1'b0);
        push(2, 8'h88, 1'b1);
        wait_idle("to_timeout", 200);
        chk("to_gap", 32'(to_gap), 32'd8);
        chk("to_pulses", 32'(to_pulses), 32'd1);
        chk("to_count", 32'(dat_log.size()), 32'd2);
        if (dat_log.size() == 2) begin
            chk("to_first", 32'(dat_log[0]), 32'h77);
            chk("to_next", 32'(dat_log[1]), 32'h88);
            chk("to_next_own", 32'(own_log[1]), 32'd2);
        end
`else
        chk("b2_timeout_off", 32'(b_to), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter and sequencer that shares one UART transmitter among `NUM_REQ` byte-stream requesters. Each requester presents bytes with valid/ready and marks the final byte of a packet with `last`. The block grants one requester at a time, feeds its bytes to the transmitter one per `tx_done`, and holds the grant until end of packet or `MAX_BURST` bytes. It sits between on-chip message sources (command responder, status reporter, debug) and the UART Tx serializer.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `MAX_BURST`, default 16: maximum bytes per grant before forced release, 1..255.
- `TIMEOUT_CYC`, default 1024: idle-grant watchdog limit in clk cycles; used only with `UART_ARB_TIMEOUT_EN`.
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `req_valid`, input, NUM_REQ: per-requester byte valid.
- `req_data`, input, 8*NUM_REQ: byte for requester i in bits [8i+7:8i].
- `req_last`, input, NUM_REQ: byte is last of packet.
- `req_ready`, output, NUM_REQ: byte consumed this cycle. Combinational.
- `grant`, output, NUM_REQ: one-hot current owner. Registered; all-zero when idle.
- `tx_start`, output, 1: one-cycle pulse to the Tx that starts a byte. Registered.
- `tx_data`, output, 8: byte for the Tx, stable from `tx_start` until `tx_done`. Registered.
- `tx_done`, input, 1: one-cycle clk-domain pulse from the Tx when the stop bit completes.
- `timeout_err`, output, 1: one-cycle pulse when the watchdog revokes a grant. Tied 0 without the macro.

## Operation
- Reset values: `grant`=0, `tx_start`=0, `tx_data`=8'h00, `timeout_err`=0, state IDLE, `burst_cnt`=0, priority pointer = NUM_REQ-1 (requester 0 highest after reset).
- **IDLE:** `grant`=0, `req_ready`=0.
  - If any `req_valid`, pick the first set index searching from pointer+1 modulo NUM_REQ.
  - Register the one-hot `grant`, clear `burst_cnt`, go to LOAD.
- **LOAD:** `req_ready[g]` = `req_valid[g]`.
  - On handshake: register `tx_data` = that byte, set `tx_start`=1 for the next cycle, latch `last_q` = `req_last[g]`, increment `burst_cnt`, go to WAIT.
  - Without handshake: stay in LOAD with the grant held.
- **WAIT:** `req_ready`=0. `tx_start` is high only in the first WAIT cycle.
  - On `tx_done`, if `last_q`=1 or `burst_cnt`==MAX_BURST: pointer ← g, `grant`←0, go to IDLE.
  - Otherwise go to LOAD.
- `tx_done` is ignored outside WAIT. `tx_done` in the same cycle as `tx_start` is ignored (the Tx cannot finish in 0 cycles).
- `req_valid` of non-granted requesters never affects the current grant.
- `req_data`/`req_last` are sampled only on handshake.
- `burst_cnt` is 8 bits and saturates; no wrap.
- Reset mid-operation aborts the transfer. No `tx_start` is issued, and a consumed-but-unsent byte is lost. The Tx shares `rst_n`.

## Timing
- Request latency:
  - `req_valid` first seen in IDLE at cycle 0.
  - `grant` and `req_ready` at cycle 1.
  - `tx_start` and `tx_data` at cycle 2.
- Inter-byte latency: `tx_done` at cycle k → LOAD at k+1 (ready if valid) → `tx_start` at k+2.
- Packet end: `tx_done` at k → IDLE at k+1 → next grant at k+2.
- At most one `tx_start` between consecutive `tx_done` pulses.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A counter runs while in LOAD with `req_valid[g]`=0.
  - Reaching TIMEOUT_CYC releases the grant (pointer ← g, go to IDLE) and pulses `timeout_err` for one cycle.
  - The counter clears on every handshake and on entry to LOAD.
- Not defined: no counter. LOAD waits indefinitely, and `timeout_err` is constant 0.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding (IDLE, LOAD, WAIT);
  - the byte width constant (8);
  - the default `MAX_BURST` and `TIMEOUT_CYC`.
- Sub-module `uart_rr_pick`: combinational round-robin selector with inputs (request vector, pointer) and outputs (one-hot, index, any). Reusable for other shared UART resources.

## Test plan
- **Single requester:** req 1 sends 8'hA5 with last=1.
  - `grant`=4'b0010 at cycle 1; `tx_start` with `tx_data`=A5 at cycle 2.
  - After `tx_done`, `grant`=0 and the pointer is at 1.
- **Round-robin:** all 4 requesters continuously valid with 1-byte packets, data = index.
  - Order after reset is 0,1,2,3,0.
  - Exactly one `tx_start` per `tx_done`.
- **Packet lock:** req 0 sends 3 bytes 11,22,33 (last on 33) while req 2 is valid.
  - All three bytes go out before req 2 is granted.
  - `tx_data` is held stable each byte until its `tx_done`.
- **MAX_BURST=2:** req 3 sends a 5-byte packet and req 0 is valid.
  - Grant sequence is 3,0,3,… with release after the 2nd byte.
  - `burst_cnt` resets on each grant.
- **Reset and stray done:**
  - `rst_n`=0 during WAIT → all outputs at reset values on the next edge, and no further `tx_start`.
  - Spurious `tx_done` in IDLE is ignored.
- **Timeout (macro on, TIMEOUT_CYC=8):** req 1 is granted, then drops valid before last.
  - `timeout_err` pulses 8 cycles after entering LOAD, the grant releases, and req 2 is served next.
